booth_mult_r4_param: RTL

- Parametrised, iterative radix-4 Booth multiplier; successor to the fixed 32-bit multiply unit in the multdiv path.
- Generalised operand width; per-operation signed/unsigned mode; full 2W-bit product (hi and lo halves); start/busy/result_ready handshake.
- Explicit overflow for both modes.
- Sits beside the divider in multdiv; driven by the execute-stage multdiv controller.

---
 rtl/booth_mult_r4_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/booth_mult_r4_param.sv
// rtl/booth_mult_r4_param.sv - iterative radix-4 Booth multiplier, signed/unsigned, full 2W-bit product
module booth_mult_r4_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             is_signed,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             ovf
);

  localparam int N  = WIDTH/2 + 1;
  localparam int HW = WIDTH + 3;
  localparam int MW = WIDTH + 2;
  localparam int AW = HW + MW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [HW-1:0]    r_mcand;
  logic [AW-1:0]    r_acc;
  logic             r_signed;
  logic             r_busy;
  logic             r_ready;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_ovf;

  logic [HW-1:0]      w_a_ext;
  logic [MW-1:0]      w_b_ext;
  logic [HW-1:0]      w_m2;
  logic [HW-1:0]      w_pp;
  logic [HW-1:0]      w_sum;
  logic [AW-1:0]      w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_ovf;

  assign w_a_ext = is_signed ? {{3{operand_a[WIDTH-1]}}, operand_a} : {3'b000, operand_a};
  assign w_b_ext = is_signed ? {{2{operand_b[WIDTH-1]}}, operand_b} : {2'b00, operand_b};
  assign w_m2    = {r_mcand[HW-2:0], 1'b0};

  // Booth digit from {b(i+1), b(i), b(i-1)}; the guard bit sits at r_acc[0]
  always_comb begin
    w_pp = '0;
    case (r_acc[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = -w_m2;
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum      = r_acc[AW-1:MW+1] + w_pp;
  assign w_acc_next = {{2{w_sum[HW-1]}}, w_sum, r_acc[MW:2]};
  assign w_prod     = w_acc_next[2*WIDTH:1];
  assign w_ovf      = r_signed ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                               : (w_prod[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand  <= w_a_ext;
            r_acc    <= {{HW{1'b0}}, w_b_ext, 1'b0};
            r_signed <= is_signed;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          // outputs only move on the final iteration so they hold through later runs
          if (r_cnt == CNT_W'(N-1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_lo    <= w_prod[WIDTH-1:0];
            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_ovf   <= w_ovf;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_ready = r_ready;
  assign product_lo   = r_lo;
  assign product_hi   = r_hi;
  assign ovf          = r_ovf;

endmodule
